// File: rtl/ysyx_23060203_bus_arb.sv
// Single-outstanding arbiter that merges the CPU read path and the LSU write path onto one SoC AXI port.
// Define YSYX_23060203_BUSARB_RR_EN for round-robin ties; by default a write wins every tie.
//   state | meaning
//   IDLE  | nothing granted; requests are arbitrated into a registered grant
//   RD    | read master owns soc_ar / soc_r
//   WR    | write master owns soc_aw / soc_w / soc_b
module ysyx_23060203_bus_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rd_arvalid,
  output logic                rd_arready,
  input  logic [ADDR_W-1:0]   rd_araddr,
  input  logic [ID_W-1:0]     rd_arid,
  input  logic [7:0]          rd_arlen,
  input  logic [2:0]          rd_arsize,
  input  logic [1:0]          rd_arburst,
  output logic                rd_rvalid,
  input  logic                rd_rready,
  output logic [DATA_W-1:0]   rd_rdata,
  output logic [1:0]          rd_rresp,
  output logic                rd_rlast,
  output logic [ID_W-1:0]     rd_rid,
  input  logic                wr_awvalid,
  output logic                wr_awready,
  input  logic [ADDR_W-1:0]   wr_awaddr,
  input  logic [ID_W-1:0]     wr_awid,
  input  logic [7:0]          wr_awlen,
  input  logic [2:0]          wr_awsize,
  input  logic [1:0]          wr_awburst,
  input  logic                wr_wvalid,
  output logic                wr_wready,
  input  logic [DATA_W-1:0]   wr_wdata,
  input  logic [DATA_W/8-1:0] wr_wstrb,
  input  logic                wr_wlast,
  output logic                wr_bvalid,
  input  logic                wr_bready,
  output logic [1:0]          wr_bresp,
  output logic [ID_W-1:0]     wr_bid,
  output logic                soc_awvalid,
  input  logic                soc_awready,
  output logic [ADDR_W-1:0]   soc_awaddr,
  output logic [ID_W-1:0]     soc_awid,
  output logic [7:0]          soc_awlen,
  output logic [2:0]          soc_awsize,
  output logic [1:0]          soc_awburst,
  output logic                soc_wvalid,
  input  logic                soc_wready,
  output logic [DATA_W-1:0]   soc_wdata,
  output logic [DATA_W/8-1:0] soc_wstrb,
  output logic                soc_wlast,
  input  logic                soc_bvalid,
  output logic                soc_bready,
  input  logic [1:0]          soc_bresp,
  input  logic [ID_W-1:0]     soc_bid,
  output logic                soc_arvalid,
  input  logic                soc_arready,
  output logic [ADDR_W-1:0]   soc_araddr,
  output logic [ID_W-1:0]     soc_arid,
  output logic [7:0]          soc_arlen,
  output logic [2:0]          soc_arsize,
  output logic [1:0]          soc_arburst,
  input  logic                soc_rvalid,
  output logic                soc_rready,
  input  logic [DATA_W-1:0]   soc_rdata,
  input  logic [1:0]          soc_rresp,
  input  logic                soc_rlast,
  input  logic [ID_W-1:0]     soc_rid,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_e;

  state_e state_q, state_d;
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   tie_rd;

`ifdef YSYX_23060203_BUSARB_RR_EN
  logic last_grant_q, last_grant_d;  // 1: write was granted last

  assign tie_rd       = last_grant_q;
  assign last_grant_d = (state_q != IDLE) ? last_grant_q :
                        (state_d == WR)   ? 1'b1 :
                        (state_d == RD)   ? 1'b0 : last_grant_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`else
  assign tie_rd = 1'b0;
`endif

  // Payload fields pass through unconditionally; only handshake signals are gated.
  assign soc_araddr  = rd_araddr;
  assign soc_arid    = rd_arid;
  assign soc_arlen   = rd_arlen;
  assign soc_arsize  = rd_arsize;
  assign soc_arburst = rd_arburst;
  assign rd_rdata    = soc_rdata;
  assign rd_rresp    = soc_rresp;
  assign rd_rlast    = soc_rlast;
  assign rd_rid      = soc_rid;
  assign soc_awaddr  = wr_awaddr;
  assign soc_awid    = wr_awid;
  assign soc_awlen   = wr_awlen;
  assign soc_awsize  = wr_awsize;
  assign soc_awburst = wr_awburst;
  assign soc_wdata   = wr_wdata;
  assign soc_wstrb   = wr_wstrb;
  assign soc_wlast   = wr_wlast;
  assign wr_bresp    = soc_bresp;
  assign wr_bid      = soc_bid;

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    ar_done_d   = ar_done_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    soc_arvalid = 1'b0;
    soc_rready  = 1'b0;
    soc_awvalid = 1'b0;
    soc_wvalid  = 1'b0;
    soc_bready  = 1'b0;
    rd_arready  = 1'b0;
    rd_rvalid   = 1'b0;
    wr_awready  = 1'b0;
    wr_wready   = 1'b0;
    wr_bvalid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_arvalid && (!wr_awvalid || tie_rd)) state_d = RD;
        else if (wr_awvalid)                       state_d = WR;
      end
      RD: begin
        soc_arvalid = rd_arvalid & ~ar_done_q;
        rd_arready  = soc_arready & ~ar_done_q;
        rd_rvalid   = soc_rvalid;
        soc_rready  = rd_rready;
        if (rd_arvalid && soc_arready && !ar_done_q) ar_done_d = 1'b1;
        if (ar_done_q && soc_rvalid && rd_rready && soc_rlast) begin
          state_d   = IDLE;
          ar_done_d = 1'b0;
        end
      end
      WR: begin
        soc_awvalid = wr_awvalid & ~aw_done_q;
        wr_awready  = soc_awready & ~aw_done_q;
        soc_wvalid  = wr_wvalid & ~w_done_q;
        wr_wready   = soc_wready & ~w_done_q;
        wr_bvalid   = soc_bvalid;
        soc_bready  = wr_bready;
        if (wr_awvalid && soc_awready && !aw_done_q)          aw_done_d = 1'b1;
        if (wr_wvalid && soc_wready && wr_wlast && !w_done_q) w_done_d  = 1'b1;
        // A B beat before both address and last data are accepted is ignored.
        if (aw_done_q && w_done_q && soc_bvalid && wr_bready) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_bus_arb.sv
// Bench for ysyx_23060203_bus_arb: directed scenarios plus random traffic, checked against a
// transaction-level ownership model of the arbiter. Build with YSYX_23060203_BUSARB_RR_EN for round-robin.
`timescale 1ns/1ps
module tb_ysyx_23060203_bus_arb;

`ifdef YSYX_23060203_BUSARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        rd_arvalid, rd_arready, rd_rvalid, rd_rready, rd_rlast;
  logic [31:0] rd_araddr, rd_rdata;
  logic [3:0]  rd_arid, rd_rid;
  logic [7:0]  rd_arlen;
  logic [2:0]  rd_arsize;
  logic [1:0]  rd_arburst, rd_rresp;
  logic        wr_awvalid, wr_awready, wr_wvalid, wr_wready, wr_wlast, wr_bvalid, wr_bready;
  logic [31:0] wr_awaddr, wr_wdata;
  logic [3:0]  wr_awid, wr_bid, wr_wstrb;
  logic [7:0]  wr_awlen;
  logic [2:0]  wr_awsize;
  logic [1:0]  wr_awburst, wr_bresp;
  logic        soc_awvalid, soc_awready, soc_wvalid, soc_wready, soc_wlast, soc_bvalid, soc_bready;
  logic [31:0] soc_awaddr, soc_wdata;
  logic [3:0]  soc_awid, soc_bid, soc_wstrb;
  logic [7:0]  soc_awlen;
  logic [2:0]  soc_awsize;
  logic [1:0]  soc_awburst, soc_bresp;
  logic        soc_arvalid, soc_arready, soc_rvalid, soc_rready, soc_rlast;
  logic [31:0] soc_araddr, soc_rdata;
  logic [3:0]  soc_arid, soc_rid;
  logic [7:0]  soc_arlen;
  logic [2:0]  soc_arsize;
  logic [1:0]  soc_arburst, soc_rresp;
  logic        busy;

  ysyx_23060203_bus_arb dut (
    .clock(clock), .reset(reset),
    .rd_arvalid(rd_arvalid), .rd_arready(rd_arready), .rd_araddr(rd_araddr), .rd_arid(rd_arid),
    .rd_arlen(rd_arlen), .rd_arsize(rd_arsize), .rd_arburst(rd_arburst),
    .rd_rvalid(rd_rvalid), .rd_rready(rd_rready), .rd_rdata(rd_rdata), .rd_rresp(rd_rresp),
    .rd_rlast(rd_rlast), .rd_rid(rd_rid),
    .wr_awvalid(wr_awvalid), .wr_awready(wr_awready), .wr_awaddr(wr_awaddr), .wr_awid(wr_awid),
    .wr_awlen(wr_awlen), .wr_awsize(wr_awsize), .wr_awburst(wr_awburst),
    .wr_wvalid(wr_wvalid), .wr_wready(wr_wready), .wr_wdata(wr_wdata), .wr_wstrb(wr_wstrb),
    .wr_wlast(wr_wlast), .wr_bvalid(wr_bvalid), .wr_bready(wr_bready), .wr_bresp(wr_bresp),
    .wr_bid(wr_bid),
    .soc_awvalid(soc_awvalid), .soc_awready(soc_awready), .soc_awaddr(soc_awaddr),
    .soc_awid(soc_awid), .soc_awlen(soc_awlen), .soc_awsize(soc_awsize), .soc_awburst(soc_awburst),
    .soc_wvalid(soc_wvalid), .soc_wready(soc_wready), .soc_wdata(soc_wdata), .soc_wstrb(soc_wstrb),
    .soc_wlast(soc_wlast), .soc_bvalid(soc_bvalid), .soc_bready(soc_bready), .soc_bresp(soc_bresp),
    .soc_bid(soc_bid),
    .soc_arvalid(soc_arvalid), .soc_arready(soc_arready), .soc_araddr(soc_araddr),
    .soc_arid(soc_arid), .soc_arlen(soc_arlen), .soc_arsize(soc_arsize), .soc_arburst(soc_arburst),
    .soc_rvalid(soc_rvalid), .soc_rready(soc_rready), .soc_rdata(soc_rdata), .soc_rresp(soc_rresp),
    .soc_rlast(soc_rlast), .soc_rid(soc_rid),
    .busy(busy)
  );

  int n_chk = 0, n_pass = 0, cyc = 0;
  int p_rdy = 100;
  // Ownership model: 0 none, 1 read master, 2 write master.
  int owner = 0;
  bit m_ar_done, m_aw_done, m_w_done, m_last_wr;
  // Read master
  bit rm_act, rm_ar_sent; logic [31:0] rm_addr, rd_base; logic [7:0] rm_len; logic [3:0] rm_id; int rm_beat;
  // Write master
  bit wm_act, wm_aw_sent, wm_w_sent; logic [31:0] wm_addr, wm_data; logic [3:0] wm_id;
  int wm_awdelay, wm_wdelay; logic [1:0] wr_resp;
  // SoC slave
  bit sr_act, sr_rv; logic [31:0] sr_base; logic [7:0] sr_len, sr_beat; logic [3:0] sr_id;
  bit sw_aw, sw_w, sw_bpend; int sw_bdelay; logic [1:0] sw_resp; logic [3:0] sw_id;
  // Observations
  int obs_log[$];
  int ar_cyc, rd_done, wr_done, b_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  function automatic bit chance(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic clear_env();
    owner = 0; m_ar_done = 0; m_aw_done = 0; m_w_done = 0; m_last_wr = 1'b1;
    rm_act = 0; rm_ar_sent = 0; rm_beat = 0; wm_act = 0; wm_aw_sent = 0; wm_w_sent = 0;
    sr_act = 0; sr_rv = 0; sw_aw = 0; sw_w = 0; sw_bpend = 0; sw_bdelay = 0;
  endtask

  // Called at a falling edge: drive, check, then advance to the next falling edge.
  task automatic tick();
    bit rd_end, wr_end, s_ar, s_r, s_aw, s_w, s_b, m_ar, m_r, m_aw, m_w, m_b;
    int win;
    rd_arvalid = rm_act && !rm_ar_sent;
    rd_araddr = rm_addr; rd_arlen = rm_len; rd_arid = rm_id; rd_arsize = 3'd2; rd_arburst = 2'b01;
    rd_rready = chance(p_rdy);
    wr_awvalid = wm_act && !wm_aw_sent && wm_awdelay == 0;
    wr_awaddr = wm_addr; wr_awid = wm_id; wr_awlen = 8'd0; wr_awsize = 3'd2; wr_awburst = 2'b01;
    wr_wvalid = wm_act && !wm_w_sent && wm_wdelay == 0;
    wr_wdata = wm_data; wr_wstrb = 4'hF; wr_wlast = 1'b1;
    wr_bready = chance(p_rdy);
    soc_arready = chance(p_rdy); soc_awready = chance(p_rdy); soc_wready = chance(p_rdy);
    if (sr_act && !sr_rv) sr_rv = chance(p_rdy);
    soc_rvalid = sr_rv; soc_rdata = sr_base + 32'(sr_beat); soc_rlast = (sr_beat == sr_len);
    soc_rid = sr_id; soc_rresp = 2'b00;
    soc_bvalid = sw_bpend && sw_bdelay == 0; soc_bresp = sw_resp; soc_bid = sw_id;
    #1;
    check("busy", busy, owner != 0);
    check("soc_arvalid", soc_arvalid, owner == 1 && rd_arvalid && !m_ar_done);
    check("soc_rready", soc_rready, owner == 1 && rd_rready);
    check("rd_rvalid", rd_rvalid, owner == 1 && soc_rvalid);
    check("rd_ar_hs", rd_arvalid && rd_arready, owner == 1 && rd_arvalid && soc_arready && !m_ar_done);
    check("soc_awvalid", soc_awvalid, owner == 2 && wr_awvalid && !m_aw_done);
    check("soc_wvalid", soc_wvalid, owner == 2 && wr_wvalid);
    check("soc_bready", soc_bready, owner == 2 && wr_bready);
    check("wr_bvalid", wr_bvalid, owner == 2 && soc_bvalid);
    check("wr_aw_hs", wr_awvalid && wr_awready, owner == 2 && wr_awvalid && soc_awready && !m_aw_done);
    check("wr_w_hs", wr_wvalid && wr_wready, owner == 2 && wr_wvalid && soc_wready);
    s_ar = soc_arvalid && soc_arready; s_r = soc_rvalid && soc_rready;
    s_aw = soc_awvalid && soc_awready; s_w = soc_wvalid && soc_wready; s_b = soc_bvalid && soc_bready;
    m_ar = rd_arvalid && rd_arready; m_r = rd_rvalid && rd_rready;
    m_aw = wr_awvalid && wr_awready; m_w = wr_wvalid && wr_wready; m_b = wr_bvalid && wr_bready;
    rd_end = owner == 1 && m_ar_done && soc_rvalid && rd_rready && soc_rlast;
    wr_end = owner == 2 && m_aw_done && m_w_done && soc_bvalid && wr_bready;
    if (owner == 1 && rd_arvalid && soc_arready) m_ar_done = 1;
    if (owner == 2 && wr_awvalid && soc_awready) m_aw_done = 1;
    if (owner == 2 && wr_wvalid && wr_wlast && soc_wready) m_w_done = 1;
    if (owner == 0) begin
      win = 0;
      if (rd_arvalid && wr_awvalid) win = (RR && m_last_wr) ? 1 : 2;
      else if (rd_arvalid)          win = 1;
      else if (wr_awvalid)          win = 2;
      if (win != 0) m_last_wr = (win == 2);
      owner = win;
    end else if (rd_end || wr_end) begin
      owner = 0; m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
    end
    if (s_r) begin
      sr_rv = 0;
      if (sr_beat == sr_len) sr_act = 0; else sr_beat++;
    end
    if (s_ar) begin
      check("ar_addr", soc_araddr, rm_addr);
      check("ar_len", soc_arlen, rm_len);
      check("ar_id", soc_arid, rm_id);
      sr_act = 1; sr_beat = 0; sr_len = soc_arlen; sr_base = rd_base; sr_id = soc_arid;
      ar_cyc = cyc; obs_log.push_back(1);
    end
    if (m_ar) rm_ar_sent = 1;
    if (m_r) begin
      check("r_data", rd_rdata, rd_base + 32'(rm_beat));
      check("r_last", rd_rlast, rm_beat == int'(rm_len));
      check("r_id", rd_rid, rm_id);
      if (rd_rlast) begin rm_act = 0; rd_done++; end
      rm_beat++;
    end
    if (s_aw) begin
      check("aw_addr", soc_awaddr, wm_addr);
      check("aw_id", soc_awid, wm_id);
      sw_aw = 1; sw_id = soc_awid; obs_log.push_back(2);
    end
    if (s_w) begin
      check("w_data", soc_wdata, wm_data);
      check("w_strb", soc_wstrb, 4'hF);
      sw_w = 1;
    end
    if (s_b) begin
      sw_bpend = 0; sw_aw = 0; sw_w = 0; b_cnt++;
    end else begin
      if (sw_bpend && sw_bdelay > 0) sw_bdelay--;
      if (sw_aw && sw_w && !sw_bpend) begin
        sw_bpend = 1; sw_bdelay = $urandom_range(3); sw_resp = wr_resp;
      end
    end
    if (m_aw) wm_aw_sent = 1;
    if (m_w)  wm_w_sent = 1;
    if (wm_act && wm_awdelay > 0) wm_awdelay--;
    if (wm_act && wm_wdelay > 0)  wm_wdelay--;
    if (m_b) begin
      check("b_resp", wr_bresp, wr_resp);
      check("b_id", wr_bid, wm_id);
      wm_act = 0; wr_done++;
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic rd_start(input logic [31:0] a, input logic [7:0] len, input logic [31:0] base);
    rm_act = 1; rm_ar_sent = 0; rm_addr = a; rm_len = len; rm_beat = 0; rd_base = base;
    rm_id = 4'($urandom_range(15));
  endtask

  task automatic wr_start(input logic [31:0] a, input logic [31:0] d, input int awd, input int wd,
                          input logic [1:0] resp);
    wm_act = 1; wm_aw_sent = 0; wm_w_sent = 0; wm_addr = a; wm_data = d;
    wm_awdelay = awd; wm_wdelay = wd; wr_resp = resp; wm_id = 4'($urandom_range(15));
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((rm_act || wm_act || owner != 0) && n < max) begin tick(); n++; end
    check("drain_done", rm_act || wm_act || owner != 0, 0);
    tick();
  endtask

  // Assert reset with every input toggled active so that output gating is exercised.
  task automatic do_reset();
    rd_arvalid = 1; rd_rready = 1; wr_awvalid = 1; wr_wvalid = 1; wr_bready = 1;
    soc_arready = 1; soc_awready = 1; soc_wready = 1; soc_rvalid = 1; soc_bvalid = 1;
    reset = 1'b0;
    #1;
    check("rst_outs", {busy, soc_arvalid, soc_awvalid, soc_wvalid, soc_rready, soc_bready,
                       rd_arready, rd_rvalid, wr_awready, wr_wready, wr_bvalid}, 0);
    clear_env();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int c0, b0, r0, w0, nrd, nwr, first;
    clear_env();
    rd_done = 0; wr_done = 0; b_cnt = 0; ar_cyc = -1;
    @(negedge clock);
    do_reset();

    // Single read, fully ready SoC: address reaches SoC one cycle after the request.
    p_rdy = 100;
    c0 = cyc;
    rd_start(32'h8000_0000, 8'd0, 32'h1234_5678);
    drain(50);
    check("rd_grant_lat", ar_cyc - c0, 1);
    check("rd_count", rd_done, 1);

    // Write with W two cycles ahead of AW: exactly one B response.
    b0 = b_cnt;
    wr_start(32'h0F00_0010, 32'hDEAD_BEEF, 2, 0, 2'b00);
    drain(50);
    check("b_once", b_cnt - b0, 1);
    check("wr_count", wr_done, 1);

    // Four simultaneous read/write request pairs.
    first = RR ? 1 : 2;
    obs_log.delete();
    for (int r = 0; r < 4; r++) begin
      rd_start(32'h8000_1000 + 32'(r * 16), 8'd0, 32'h5000_0000 + 32'(r));
      wr_start(32'h0F00_0100 + 32'(r * 16), 32'hA5A5_0000 + 32'(r), 0, 0, 2'b00);
      drain(100);
    end
    check("tie_count", obs_log.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("tie_order%0d", i), (i < obs_log.size()) ? obs_log[i] : 0,
            (i % 2 == 0) ? first : 3 - first);

    // Burst read of four beats with a write arriving mid-burst.
    obs_log.delete();
    p_rdy = 70;
    rd_start(32'h8000_2000, 8'd3, 32'h7700_0000);
    tick();
    wr_start(32'h0F00_0200, 32'h0BAD_F00D, 0, 0, 2'b10);
    drain(200);
    check("iso_order0", (obs_log.size() > 0) ? obs_log[0] : 0, 1);
    check("iso_order1", (obs_log.size() > 1) ? obs_log[1] : 0, 2);
    check("iso_beats", rm_beat, 4);

    // Reset after the AW handshake while W is still held back.
    p_rdy = 100;
    wr_start(32'h0F00_0300, 32'h1111_2222, 0, 20, 2'b00);
    for (int n = 0; n < 10 && !m_aw_done; n++) tick();
    check("aw_before_rst", m_aw_done, 1);
    do_reset();
    r0 = rd_done;
    rd_start(32'h8000_3000, 8'd1, 32'h3300_0000);
    drain(50);
    check("rd_after_rst", rd_done - r0, 1);

    // Random traffic.
    r0 = rd_done; w0 = wr_done; nrd = 0; nwr = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) p_rdy = $urandom_range(30, 100);
      if (!rm_act && chance(30)) begin
        rd_start($urandom, 8'($urandom_range(3)), $urandom);
        nrd++;
      end
      if (!wm_act && chance(30)) begin
        wr_start($urandom, $urandom, $urandom_range(3), $urandom_range(3), 2'($urandom_range(3)));
        nwr++;
      end
      tick();
    end
    p_rdy = 100;
    drain(500);
    check("rand_rd_count", rd_done - r0, nrd);
    check("rand_wr_count", wr_done - w0, nwr);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_23060203_bus_arb.md
# ysyx_23060203_bus_arb

Single-outstanding AXI arbiter between the CPU read path (MemArb→XBar SoC branch) and the LSU write path, driving the one SoC AXI master port. It serializes read and write transactions so the SoC never sees a read and a write in flight at the same time. This removes the shared-port hazard on the SoC interface and gives a defined read-after-write order. It sits between XBar/EXU and the top-level SoC port.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports (signal widths are those of the standard axi_if; one clock domain; reset is asynchronous and active-low):
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rd_ar{valid,ready,addr,id,len,size,burst}  in/out  std  read-master address channel (XBar SoC branch)
- rd_r{valid,ready,data,resp,last,id}  out/in  std  read-master data channel
- wr_aw{valid,ready,addr,id,len,size,burst}  in/out  std  write-master address channel (LSU)
- wr_w{valid,ready,data,strb,last}  in/out  std  write-master data channel
- wr_b{valid,ready,resp,id}  out/in  std  write-master response channel
- soc_*  out/in  std  full read+write AXI master port to the SoC
- busy  out  1  high while any transaction is granted

## Operation
- FSM states: IDLE, RD, WR.
- IDLE:
  - Sample rd_arvalid and wr_awvalid.
  - Only read pending → RD. Only write pending → WR. Neither → stay in IDLE.
  - Both pending → choose by arbitration policy (see Configuration).
- RD:
  - soc_ar* and soc_r* connect combinationally to rd_*.
  - Track ar_done, set on the soc_ar handshake.
  - Exit to IDLE on soc_rvalid & soc_rready & soc_rlast, with ar_done set.
- WR:
  - soc_aw*, soc_w*, and soc_b* connect combinationally to wr_*.
  - AW and W forward independently, in either order or in the same cycle. aw_done and w_done are set on their handshakes; w_done is set only on wlast.
  - Exit to IDLE on the soc_b handshake, with aw_done and w_done both set.
- Ungranted master:
  - Its ready outputs (arready/awready/wready) are 0.
  - Its response valids (rvalid/bvalid) are 0.
  - Its request is held; it is served later and never dropped.
- Gating of SoC outputs:
  - In IDLE, all soc_*valid and soc_*ready outputs are 0.
  - In RD, all write-channel valid/ready to the SoC are 0, and vice versa in WR.
  - Once the address handshake is done (ar_done or aw_done set), soc_arvalid/soc_awvalid is forced to 0.
- Responses: soc_rresp and soc_bresp pass through unmodified; error handling stays in the CPU.
- busy = (state != IDLE).
- Reset: async assertion forces IDLE, clears ar_done/aw_done/w_done and the last-grant register, and drives all valid/ready outputs to 0. A transaction in flight is abandoned; the SoC is reset by the same signal.

## Timing
- Grant latency: a request first seen in IDLE in cycle N is forwarded to the SoC in cycle N+1. Arbitration is registered; there is no combinational valid path from IDLE.
- Back-to-back transactions:
  - Minimum of one IDLE cycle between the last response handshake and the next grant.
  - Per-transaction overhead is 1 cycle plus the SoC latency.
- While granted, all channel signals are zero-latency combinational pass-through.
- Response handshake and a new request in the same cycle: the new request is not granted that cycle; it is evaluated in the following IDLE cycle.
- Request drop: a master deasserting valid before its handshake violates AXI. The behaviour is undefined but must not deadlock: RD/WR still exits only on the response.

## Configuration
- Macro: YSYX_23060203_BUSARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_grant register is updated at each grant.
  - On a tie, the master not granted last wins.
  - Reset value of last_grant = write, so the first tie goes to read.
- Undefined: fixed priority, write wins every tie. This preserves store-before-load order when the LSU write and a fetch collide. No last_grant register is present.

## Test plan
- Read only: rd_araddr=0x8000_0000 issued in IDLE → soc_arvalid=1 one cycle later. rd_rdata=0x1234_5678 with rlast → state returns to IDLE and busy drops the next cycle.
- Write only, W before AW: wr_wvalid (data 0xDEAD_BEEF, strb 0xF) two cycles before wr_awvalid (addr 0x0F00_0010). Both handshake → exactly one soc_b is forwarded to wr_b, with bresp=0.
- Simultaneous requests, macro undefined: write granted first and read stalled (rd_arready=0) until bvalid. The read is granted one IDLE cycle later.
- Simultaneous requests repeated 4 times, YSYX_23060203_BUSARB_RR_EN defined: grant order read, write, read, write.
- Isolation: a read burst of len=3 in progress with a write pending → no soc_aw/soc_w activity until after the 4th beat with rlast.
- Reset mid-WR, after the AW handshake: assert reset → all valids 0 and busy=0 immediately. After deassertion, a fresh read completes normally.
